// File: rtl/uart_frame_parser_if.sv
// ---------------------------------------------------------------------------
// uart_frame_parser_if
//
// Groups the byte-level handshake signals of uart_frame_parser.
//   in_data   [7:0]  received byte from the UART receiver
//   in_valid         one-cycle pulse per received byte
//   out_data  [7:0]  verified payload byte
//   out_valid        out_data holds a verified payload byte
//   out_ready        downstream consumer accepts out_data
//   out_last         marks the final payload byte of a frame
//
// Modports:
//   slave  - the parser's view (consumes bytes, produces the payload stream)
//   master - the environment's view (UART receiver plus payload consumer)
// ---------------------------------------------------------------------------
interface uart_frame_parser_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, out_last
  );
endinterface

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
//
// Assembles bytes from a UART receiver into frames of the form
//   SYNC, LEN, LEN payload bytes, XOR checksum
// buffers the payload and releases it on a valid/ready stream only after the
// checksum (XOR of LEN and every payload byte) matches.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        uart_frame_parser_if.slave (in_*, out_* handshake signals)
//   frame_ok   one-cycle pulse when a frame's checksum matches
//   frame_err  one-cycle pulse on any error
//   err_code   sticky code of the last error: 0 LEN, 1 CHKSUM, 2 TIMEOUT,
//              3 OVERRUN
//   busy       a frame is being parsed or drained
//   o_LEDS     first payload byte of the last good frame
// ---------------------------------------------------------------------------
module uart_frame_parser #(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 104160
) (
  input  logic              clk,
  input  logic              rst,
  uart_frame_parser_if.slave bus,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [7:0]        o_LEDS
);

  localparam int AW    = $clog2(MAX_LEN);
  localparam int IDX_W = $clog2(MAX_LEN) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_CHKSUM  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [7:0]       chk_q, chk_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [7:0]       leds_q, leds_d;

  logic [7:0]       mem_q [MAX_LEN];
  logic             mem_we;
  logic             parsing;
  logic             last_byte;

  // The inter-byte silence counter only matters while a frame is being
  // received; in IDLE and DRAIN it is held at zero.
  assign parsing   = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  assign last_byte = (rd_idx_q == len_q - 1'b1);

  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = mem_q[rd_idx_q[AW-1:0]];
  assign bus.out_last  = bus.out_valid && last_byte;

  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != IDLE);
  assign o_LEDS    = leds_q;

  // Next-state logic. Every parsing state consumes at most one byte per
  // in_valid pulse; the timeout check afterwards only fires on cycles without
  // a byte, so a byte landing on the last allowed cycle still wins. The
  // counter defaults to zero, which clears it on every byte and on every
  // state entry.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    chk_d       = chk_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    tmo_d       = '0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    leds_d      = leds_q;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && (bus.in_data == SYNC_BYTE)) begin
          state_d = LEN;
        end
      end

      LEN: begin
        if (bus.in_valid) begin
          if ((bus.in_data == 8'd0) || (bus.in_data > 8'(MAX_LEN))) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = IDLE;
          end else begin
            len_d    = bus.in_data[IDX_W-1:0];
            chk_d    = bus.in_data;
            wr_idx_d = '0;
            state_d  = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (bus.in_valid) begin
          mem_we   = 1'b1;
          chk_d    = chk_q ^ bus.in_data;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == len_q - 1'b1) begin
            state_d = CHK;
          end
        end
      end

      CHK: begin
        if (bus.in_valid) begin
          if (bus.in_data == chk_q) begin
            frame_ok_d = 1'b1;
            rd_idx_d   = '0;
            leds_d     = mem_q[0];
            state_d    = DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHKSUM;
            state_d     = IDLE;
          end
        end
      end

      DRAIN: begin
        // A byte arriving while the buffer is being drained is dropped; the
        // drain handshake is handled independently in the same cycle.
        if (bus.in_valid) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        if (bus.out_ready) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (last_byte) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (parsing && !bus.in_valid) begin
      if (tmo_q == TMO_LAST) begin
        frame_err_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
        state_d     = IDLE;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      chk_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_LEN;
      leds_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      leds_q      <= leds_d;
    end
  end

  // Payload buffer. Its contents are left alone by reset; stale bytes are
  // never visible because out_valid only rises after a full frame is stored.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx_q[AW-1:0]] <= bus.in_data;
    end
  end

endmodule
